// File: rtl/agex_stage.sv
// agex_stage: ALU, LW/SW address generation, branch resolution and the AGEX latch.
// The iterative mul/div unit and its FSM are built only when AGEX_MULDIV_EN is defined.
module agex_stage #(
    parameter int DBITS      = 32,
    parameter int IOPBITS    = 6,
    parameter int TYPENOBITS = 4,
    parameter int CNTBITS    = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  de_valid,
    input  logic [31:0]           de_inst,
    input  logic [DBITS-1:0]      de_pc,
    input  logic [IOPBITS-1:0]    de_op,
    input  logic [TYPENOBITS-1:0] de_type,
    input  logic [DBITS-1:0]      de_inst_count,
    input  logic [DBITS-1:0]      de_rs1,
    input  logic [DBITS-1:0]      de_rs2,
    input  logic [DBITS-1:0]      de_imm,
    output logic                  stall_out,
    output logic                  br_taken,
    output logic [DBITS-1:0]      br_target,
    output logic [1+32+IOPBITS+TYPENOBITS+4*DBITS-1:0] agex_latch
);
    localparam int LATW = 1 + 32 + IOPBITS + TYPENOBITS + 4 * DBITS;
    localparam int SHW  = $clog2(DBITS);

    localparam logic [IOPBITS-1:0] OP_ADD   = IOPBITS'(0);
    localparam logic [IOPBITS-1:0] OP_SUB   = IOPBITS'(1);
    localparam logic [IOPBITS-1:0] OP_AND   = IOPBITS'(2);
    localparam logic [IOPBITS-1:0] OP_OR    = IOPBITS'(3);
    localparam logic [IOPBITS-1:0] OP_XOR   = IOPBITS'(4);
    localparam logic [IOPBITS-1:0] OP_SLL   = IOPBITS'(5);
    localparam logic [IOPBITS-1:0] OP_SRL   = IOPBITS'(6);
    localparam logic [IOPBITS-1:0] OP_SRA   = IOPBITS'(7);
    localparam logic [IOPBITS-1:0] OP_SLT   = IOPBITS'(8);
    localparam logic [IOPBITS-1:0] OP_SLTU  = IOPBITS'(9);
    localparam logic [IOPBITS-1:0] OP_ADDI  = IOPBITS'(10);
    localparam logic [IOPBITS-1:0] OP_ANDI  = IOPBITS'(11);
    localparam logic [IOPBITS-1:0] OP_ORI   = IOPBITS'(12);
    localparam logic [IOPBITS-1:0] OP_XORI  = IOPBITS'(13);
    localparam logic [IOPBITS-1:0] OP_SLLI  = IOPBITS'(14);
    localparam logic [IOPBITS-1:0] OP_SRLI  = IOPBITS'(15);
    localparam logic [IOPBITS-1:0] OP_SRAI  = IOPBITS'(16);
    localparam logic [IOPBITS-1:0] OP_SLTI  = IOPBITS'(17);
    localparam logic [IOPBITS-1:0] OP_SLTIU = IOPBITS'(18);
    localparam logic [IOPBITS-1:0] OP_LUI   = IOPBITS'(19);
    localparam logic [IOPBITS-1:0] OP_AUIPC = IOPBITS'(20);
    localparam logic [IOPBITS-1:0] OP_LW    = IOPBITS'(21);
    localparam logic [IOPBITS-1:0] OP_SW    = IOPBITS'(22);
    localparam logic [IOPBITS-1:0] OP_BEQ   = IOPBITS'(23);
    localparam logic [IOPBITS-1:0] OP_BNE   = IOPBITS'(24);
    localparam logic [IOPBITS-1:0] OP_BLT   = IOPBITS'(25);
    localparam logic [IOPBITS-1:0] OP_BGE   = IOPBITS'(26);
    localparam logic [IOPBITS-1:0] OP_BLTU  = IOPBITS'(27);
    localparam logic [IOPBITS-1:0] OP_BGEU  = IOPBITS'(28);
    localparam logic [IOPBITS-1:0] OP_JAL   = IOPBITS'(29);
    localparam logic [IOPBITS-1:0] OP_JALR  = IOPBITS'(30);

    logic             use_imm;
    logic             cond;
    logic [DBITS-1:0] opb;
    logic [DBITS-1:0] ea;
    logic [DBITS-1:0] link;
    logic [DBITS-1:0] res;
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] target;
    logic [SHW-1:0]   shamt;
    logic             idle;
    logic             md_stall;
    logic             md_done;
    logic [LATW-1:0]  md_word;

    assign use_imm = de_op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                                   OP_SLLI, OP_SRLI, OP_SRAI,
                                   OP_SLTI, OP_SLTIU};
    assign opb   = use_imm ? de_imm : de_rs2;
    assign shamt = opb[SHW-1:0];
    assign ea    = de_rs1 + de_imm;
    assign link  = de_pc + DBITS'(4);

    always_comb begin
        res    = '0;
        addr   = '0;
        cond   = 1'b0;
        target = de_pc + de_imm;
        unique case (de_op)
            OP_ADD, OP_ADDI:   res = de_rs1 + opb;
            OP_SUB:            res = de_rs1 - de_rs2;
            OP_AND, OP_ANDI:   res = de_rs1 & opb;
            OP_OR, OP_ORI:     res = de_rs1 | opb;
            OP_XOR, OP_XORI:   res = de_rs1 ^ opb;
            OP_SLL, OP_SLLI:   res = de_rs1 << shamt;
            OP_SRL, OP_SRLI:   res = de_rs1 >> shamt;
            OP_SRA, OP_SRAI:   res = $signed(de_rs1) >>> shamt;
            OP_SLT, OP_SLTI:   res = DBITS'($signed(de_rs1) < $signed(opb));
            OP_SLTU, OP_SLTIU: res = DBITS'(de_rs1 < opb);
            OP_LUI:            res = de_imm;
            OP_AUIPC:          res = de_pc + de_imm;
            OP_LW:             addr = ea;
            OP_SW: begin
                addr = ea;
                res  = de_rs2;
            end
            OP_BEQ:  cond = de_rs1 == de_rs2;
            OP_BNE:  cond = de_rs1 != de_rs2;
            OP_BLT:  cond = $signed(de_rs1) < $signed(de_rs2);
            OP_BGE:  cond = $signed(de_rs1) >= $signed(de_rs2);
            OP_BLTU: cond = de_rs1 < de_rs2;
            OP_BGEU: cond = de_rs1 >= de_rs2;
            OP_JAL: begin
                cond = 1'b1;
                res  = link;
            end
            OP_JALR: begin
                cond   = 1'b1;
                res    = link;
                target = {ea[DBITS-1:1], 1'b0};
            end
            default: ;
        endcase
    end

`ifdef AGEX_MULDIV_EN
    localparam logic [IOPBITS-1:0] OP_MUL   = IOPBITS'(31);
    localparam logic [IOPBITS-1:0] OP_MULH  = IOPBITS'(32);
    localparam logic [IOPBITS-1:0] OP_MULHU = IOPBITS'(33);
    localparam logic [IOPBITS-1:0] OP_DIV   = IOPBITS'(34);
    localparam logic [IOPBITS-1:0] OP_DIVU  = IOPBITS'(35);
    localparam logic [IOPBITS-1:0] OP_REM   = IOPBITS'(36);
    localparam logic [IOPBITS-1:0] OP_REMU  = IOPBITS'(37);
    localparam logic [DBITS-1:0]   SMIN     = {1'b1, {(DBITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    state_t                state_nx;
    logic [CNTBITS-1:0]    cnt;
    logic [DBITS:0]        acc;
    logic [DBITS-1:0]      lo;
    logic [DBITS-1:0]      b;
    logic [DBITS-1:0]      spec_val;
    logic [DBITS-1:0]      md_res;
    logic [DBITS-1:0]      prod_hi;
    logic [IOPBITS-1:0]    md_op;
    logic [31:0]           md_inst;
    logic [DBITS-1:0]      md_pc;
    logic [DBITS-1:0]      md_tag;
    logic [TYPENOBITS-1:0] md_type;
    logic                  neg_q;
    logic                  neg_r;
    logic                  spec;
    logic                  is_md;
    logic                  accept;
    logic                  sgn;
    logic                  sa;
    logic                  sb;
    logic                  dz;
    logic                  ovf;
    logic                  is_rem;
    logic                  md_mul;
    logic                  ge;
    logic [DBITS-1:0]      mag_a;
    logic [DBITS-1:0]      mag_b;
    logic [DBITS:0]        sum;
    logic [DBITS:0]        sh;

    assign is_md  = de_op inside {OP_MUL, OP_MULH, OP_MULHU,
                                  OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign accept = de_valid & is_md & (state == IDLE);
    assign sgn    = de_op inside {OP_MULH, OP_DIV, OP_REM};
    assign sa     = sgn & de_rs1[DBITS-1];
    assign sb     = sgn & de_rs2[DBITS-1];
    assign mag_a  = sa ? -de_rs1 : de_rs1;
    assign mag_b  = sb ? -de_rs2 : de_rs2;
    assign is_rem = de_op inside {OP_REM, OP_REMU};
    assign dz     = (de_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) &&
                    (de_rs2 == '0);
    assign ovf    = (de_op inside {OP_DIV, OP_REM}) &&
                    (de_rs1 == SMIN) && (de_rs2 == '1);

    assign md_mul = md_op inside {OP_MUL, OP_MULH, OP_MULHU};
    assign sum    = acc + (lo[0] ? {1'b0, b} : {(DBITS+1){1'b0}});
    assign sh     = {acc[DBITS-1:0], lo[DBITS-1]};
    assign ge     = sh >= {1'b0, b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = BUSY;
            BUSY:    if (cnt == CNTBITS'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        idle     = 1'b0;
        md_stall = 1'b0;
        md_done  = 1'b0;
        unique case (state)
            IDLE: begin
                idle     = 1'b1;
                md_stall = accept;
            end
            BUSY:    md_stall = 1'b1;
            DONE:    md_done  = 1'b1;
            default: ;
        endcase
    end

    // High word of the negated 2*DBITS product: ~hi plus carry out of -lo.
    always_comb begin
        prod_hi = neg_q ? ~acc[DBITS-1:0] + DBITS'(lo == '0) : acc[DBITS-1:0];
        md_res  = '0;
        unique case (md_op)
            OP_MUL:          md_res = lo;
            OP_MULH:         md_res = prod_hi;
            OP_MULHU:        md_res = acc[DBITS-1:0];
            OP_DIV, OP_DIVU: md_res = neg_q ? -lo : lo;
            default:         md_res = neg_r ? -acc[DBITS-1:0] : acc[DBITS-1:0];
        endcase
        if (spec) md_res = spec_val;
        md_word = {1'b1, md_inst, md_pc, md_op, md_type, md_tag,
                   md_res, {DBITS{1'b0}}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            lo       <= '0;
            b        <= '0;
            md_op    <= '0;
            md_inst  <= '0;
            md_pc    <= '0;
            md_tag   <= '0;
            md_type  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            spec     <= 1'b0;
            spec_val <= '0;
        end else if (accept) begin
            cnt      <= CNTBITS'(DBITS);
            acc      <= '0;
            lo       <= mag_a;
            b        <= mag_b;
            md_op    <= de_op;
            md_inst  <= de_inst;
            md_pc    <= de_pc;
            md_tag   <= de_inst_count;
            md_type  <= de_type;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            spec     <= dz | ovf;
            if (dz) spec_val <= is_rem ? de_rs1 : '1;
            else    spec_val <= is_rem ? '0 : SMIN;
        end else if (state == BUSY) begin
            cnt <= cnt - CNTBITS'(1);
            if (md_mul) begin
                acc <= {1'b0, sum[DBITS:1]};
                lo  <= {sum[0], lo[DBITS-1:1]};
            end else begin
                acc <= ge ? sh - {1'b0, b} : sh;
                lo  <= {lo[DBITS-2:0], ge};
            end
        end
    end
`else
    localparam int CNT_UNUSED = CNTBITS;

    assign idle     = 1'b1;
    assign md_stall = 1'b0;
    assign md_done  = 1'b0;
    assign md_word  = '0;
`endif

    assign stall_out = md_stall & reset;
    assign br_taken  = de_valid & idle & cond & reset;
    assign br_target = br_taken ? target : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            agex_latch <= '0;
        end else if (md_done) begin
            agex_latch <= md_word;
        end else if (!de_valid || md_stall) begin
            agex_latch <= '0;
        end else begin
            agex_latch <= {1'b1, de_inst, de_pc, de_op, de_type,
                           de_inst_count, res, addr};
        end
    end

endmodule

// File: tb/tb_agex_stage.sv
// tb_agex_stage: vector table for single-cycle ops, directed sequences
// for reset and the multi-cycle mul/div unit.
module tb_agex_stage;
    localparam int DBITS = 32;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_SRA   = 6'd7;
    localparam logic [5:0] OP_SLT   = 6'd8;
    localparam logic [5:0] OP_SLTU  = 6'd9;
    localparam logic [5:0] OP_XORI  = 6'd13;
    localparam logic [5:0] OP_SLLI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd19;
    localparam logic [5:0] OP_AUIPC = 6'd20;
    localparam logic [5:0] OP_LW    = 6'd21;
    localparam logic [5:0] OP_SW    = 6'd22;
    localparam logic [5:0] OP_BEQ   = 6'd23;
    localparam logic [5:0] OP_BNE   = 6'd24;
    localparam logic [5:0] OP_BLT   = 6'd25;
    localparam logic [5:0] OP_BGE   = 6'd26;
    localparam logic [5:0] OP_BLTU  = 6'd27;
    localparam logic [5:0] OP_BGEU  = 6'd28;
    localparam logic [5:0] OP_JAL   = 6'd29;
    localparam logic [5:0] OP_JALR  = 6'd30;
    localparam logic [5:0] OP_MUL   = 6'd31;
    localparam logic [5:0] OP_MULH  = 6'd32;
    localparam logic [5:0] OP_MULHU = 6'd33;
    localparam logic [5:0] OP_DIV   = 6'd34;
    localparam logic [5:0] OP_DIVU  = 6'd35;
    localparam logic [5:0] OP_REM   = 6'd36;
    localparam logic [5:0] OP_REMU  = 6'd37;

    logic         clk = 1'b0;
    logic         reset;
    logic         de_valid;
    logic [31:0]  de_inst;
    logic [31:0]  de_pc;
    logic [5:0]   de_op;
    logic [3:0]   de_type;
    logic [31:0]  de_inst_count;
    logic [31:0]  de_rs1;
    logic [31:0]  de_rs2;
    logic [31:0]  de_imm;
    logic         stall_out;
    logic         br_taken;
    logic [31:0]  br_target;
    logic [170:0] agex_latch;

    logic         lat_valid;
    logic [31:0]  lat_pc;
    logic [31:0]  lat_tag;
    logic [31:0]  lat_reg;
    logic [31:0]  lat_addr;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  tag_ctr = 32'd100;

    always #5 clk = ~clk;

    agex_stage #(
        .DBITS(32), .IOPBITS(6), .TYPENOBITS(4), .CNTBITS(6)
    ) dut (
        .clk(clk), .reset(reset), .de_valid(de_valid),
        .de_inst(de_inst), .de_pc(de_pc), .de_op(de_op),
        .de_type(de_type), .de_inst_count(de_inst_count),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_imm(de_imm),
        .stall_out(stall_out), .br_taken(br_taken),
        .br_target(br_target), .agex_latch(agex_latch)
    );

    assign lat_valid = agex_latch[170];
    assign lat_pc    = agex_latch[137:106];
    assign lat_tag   = agex_latch[95:64];
    assign lat_reg   = agex_latch[63:32];
    assign lat_addr  = agex_latch[31:0];

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [31:0] pc, rs1, rs2, imm;
        logic [31:0] reg_e, addr_e, tgt_e;
        logic        br_e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic [5:0] op,
                                input logic [31:0] pc, rs1, rs2, imm,
                                input logic [31:0] reg_e, addr_e,
                                input logic br_e, input logic [31:0] tgt_e);
        vec_t v;
        v.nm = nm; v.op = op; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.reg_e = reg_e; v.addr_e = addr_e;
        v.br_e = br_e; v.tgt_e = tgt_e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] pc,
                         input logic [31:0] rs1, rs2, imm);
        de_valid      = 1'b1;
        de_op         = op;
        de_inst       = {26'd0, op};
        de_type       = 4'h3;
        de_pc         = pc;
        de_rs1        = rs1;
        de_rs2        = rs2;
        de_imm        = imm;
        de_inst_count = tag_ctr;
        tag_ctr       = tag_ctr + 32'd1;
    endtask

    task automatic run_md(input string nm, input logic [5:0] op,
                          input logic [31:0] a, b, exp, input bit full);
        int edges, stalls, bubbles;
        logic st, got;
        logic [31:0] t;
        drive(op, 32'h80, a, b, 32'd0);
        t = tag_ctr - 32'd1;
        edges = 0; stalls = 0; bubbles = 0; got = 1'b0;
        while (!got && edges < 40) begin
            #1;
            st = stall_out;
            if (st) stalls++;
            @(posedge clk); #1;
            edges++;
            if (lat_valid) got = 1'b1;
            else bubbles++;
            @(negedge clk);
            if (!st) de_valid = 1'b0;
        end
        de_valid = 1'b0;
        chk({nm, " done"}, 32'(got), 32'd1);
        chk({nm, " result"}, lat_reg, exp);
        chk({nm, " tag"}, lat_tag, t);
        if (full) begin
            chk({nm, " latency"}, edges, 34);
            chk({nm, " stalls"}, stalls, 33);
            chk({nm, " bubbles"}, bubbles, 33);
        end
    endtask

    initial begin
        logic [31:0] t0;
        int n;
        logic brbad;

        reset = 1'b0; de_valid = 1'b0; de_inst = '0; de_pc = '0;
        de_op = '0; de_type = '0; de_inst_count = '0;
        de_rs1 = '0; de_rs2 = '0; de_imm = '0;
        repeat (2) @(negedge clk);
        chk("reset latch", 32'(agex_latch != '0), 32'd0);
        chk("reset stall", 32'(stall_out), 32'd0);
        chk("reset br", 32'(br_taken), 32'd0);
        chk("reset tgt", br_target, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        tbl.push_back(mk("ADD wrap", OP_ADD, 32'h40, 32'hFFFFFFFF, 32'd1, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk("SW", OP_SW, 32'h44, 32'h100, 32'hAB, 32'hFFFFFFFC, 32'hAB, 32'hFC, 0, 0));
        tbl.push_back(mk("BEQ", OP_BEQ, 32'h40, 32'd5, 32'd5, 32'h20, 0, 0, 1, 32'h60));
        tbl.push_back(mk("BNE", OP_BNE, 32'h40, 32'd5, 32'd5, 32'h20, 0, 0, 0, 0));
        tbl.push_back(mk("JALR", OP_JALR, 32'h40, 32'h101, 32'd0, 32'd0, 32'h44, 0, 1, 32'h100));
        tbl.push_back(mk("JAL", OP_JAL, 32'h40, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h44, 0, 1, 32'h30));
        tbl.push_back(mk("SUB", OP_SUB, 32'h48, 32'd3, 32'd5, 32'd0, 32'hFFFFFFFE, 0, 0, 0));
        tbl.push_back(mk("SRA", OP_SRA, 32'h4C, 32'h80000000, 32'h24, 0, 32'hF8000000, 0, 0, 0));
        tbl.push_back(mk("SLT", OP_SLT, 32'h50, 32'hFFFFFFFF, 32'd1, 0, 32'd1, 0, 0, 0));
        tbl.push_back(mk("SLTU", OP_SLTU, 32'h54, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 0, 0, 0));
        tbl.push_back(mk("LW", OP_LW, 32'h58, 32'hFFFFFFF0, 32'd7, 32'h20, 32'd0, 32'h10, 0, 0));
        tbl.push_back(mk("BLT", OP_BLT, 32'h40, 32'hFFFFFFFF, 32'd0, 32'd8, 0, 0, 1, 32'h48));
        tbl.push_back(mk("BLTU", OP_BLTU, 32'h40, 32'hFFFFFFFF, 32'd0, 32'd8, 0, 0, 0, 0));
        tbl.push_back(mk("BGE", OP_BGE, 32'h40, 32'd5, 32'd5, 32'h10, 0, 0, 1, 32'h50));
        tbl.push_back(mk("BGEU", OP_BGEU, 32'h40, 32'd1, 32'd2, 32'h10, 0, 0, 0, 0));
        tbl.push_back(mk("LUI", OP_LUI, 32'h5C, 0, 0, 32'h12345000, 32'h12345000, 0, 0, 0));
        tbl.push_back(mk("AUIPC", OP_AUIPC, 32'h40, 0, 0, 32'h1000, 32'h1040, 0, 0, 0));
        tbl.push_back(mk("SLLI", OP_SLLI, 32'h60, 32'd1, 32'd0, 32'h1F, 32'h80000000, 0, 0, 0));
        tbl.push_back(mk("XORI", OP_XORI, 32'h64, 32'hF0F0, 32'd0, 32'hFFFFFFFF, 32'hFFFF0F0F, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            t0 = tag_ctr - 32'd1;
            #1;
            chk({tbl[i].nm, " br_taken"}, 32'(br_taken), 32'(tbl[i].br_e));
            if (tbl[i].br_e) chk({tbl[i].nm, " br_target"}, br_target, tbl[i].tgt_e);
            chk({tbl[i].nm, " stall"}, 32'(stall_out), 32'd0);
            @(posedge clk); #1;
            chk({tbl[i].nm, " valid"}, 32'(lat_valid), 32'd1);
            chk({tbl[i].nm, " regval"}, lat_reg, tbl[i].reg_e);
            chk({tbl[i].nm, " memaddr"}, lat_addr, tbl[i].addr_e);
            chk({tbl[i].nm, " pc"}, lat_pc, tbl[i].pc);
            chk({tbl[i].nm, " tag"}, lat_tag, t0);
            @(negedge clk);
        end

        de_valid = 1'b0;
        @(posedge clk); #1;
        chk("bubble latch", 32'(agex_latch != '0), 32'd0);
        @(negedge clk);

        drive(OP_ADD, 32'h70, 32'd1, 32'd2, 32'd0);
        @(posedge clk); #1;
        chk("pre-reset valid", 32'(lat_valid), 32'd1);
        @(negedge clk);
        drive(OP_BEQ, 32'h40, 32'd5, 32'd5, 32'h20);
        #2 reset = 1'b0;
        #1;
        chk("async reset latch", 32'(agex_latch != '0), 32'd0);
        chk("async reset br", 32'(br_taken), 32'd0);
        chk("async reset stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("held reset latch", 32'(agex_latch != '0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        de_valid = 1'b0;
        @(negedge clk);

`ifdef AGEX_MULDIV_EN
        run_md("MUL", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
        run_md("MULH", OP_MULH, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_md("MULHU", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_md("DIV", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b1);
        run_md("REM", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
        run_md("DIVU by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);
        run_md("REM by0", OP_REM, 32'd5, 32'd0, 32'd5, 1'b0);
        run_md("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_md("REM ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0);
        run_md("DIVU", OP_DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, 1'b0);
        run_md("REMU", OP_REMU, 32'd10, 32'd3, 32'd1, 1'b0);

        drive(OP_DIV, 32'h80, 32'hFFFFFFF9, 32'd2, 32'd0);
        t0 = tag_ctr - 32'd1;
        #1;
        chk("div accept stall", 32'(stall_out), 32'd1);
        @(posedge clk);
        @(negedge clk);
        de_op = OP_BEQ; de_pc = 32'h40; de_rs1 = 32'd5;
        de_rs2 = 32'd5; de_imm = 32'h20; de_inst_count = 32'hDEAD;
        #1;
        chk("busy br_taken", 32'(br_taken), 32'd0);
        n = 0;
        brbad = 1'b0;
        while (stall_out && n < 40) begin
            @(negedge clk); #1;
            n++;
            if (br_taken) brbad = 1'b1;
        end
        chk("busy cycles", n, 32);
        chk("busy br seen", 32'(brbad), 32'd0);
        chk("done br_taken", 32'(br_taken), 32'd0);
        drive(OP_ADD, 32'h84, 32'd2, 32'd3, 32'd0);
        @(posedge clk); #1;
        chk("div valid", 32'(lat_valid), 32'd1);
        chk("div tag", lat_tag, t0);
        chk("div result", lat_reg, 32'hFFFFFFFD);
        @(negedge clk); #1;
        chk("idle stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("add valid", 32'(lat_valid), 32'd1);
        chk("add tag", lat_tag, t0 + 32'd1);
        chk("add result", lat_reg, 32'd5);
        @(negedge clk);
        de_valid = 1'b0;
        @(posedge clk); #1;
        chk("no dup valid", 32'(lat_valid), 32'd0);
        @(negedge clk);

        drive(OP_MUL, 32'h90, 32'd7, 32'd3, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        chk("busy stall", 32'(stall_out), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("busy reset stall", 32'(stall_out), 32'd0);
        chk("busy reset valid", 32'(lat_valid), 32'd0);
        @(posedge clk); #1;
        chk("busy reset held", 32'(stall_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(OP_ADD, 32'h94, 32'd1, 32'd1, 32'd0);
        #1;
        chk("post reset stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("post reset valid", 32'(lat_valid), 32'd1);
        chk("post reset result", lat_reg, 32'd2);
        @(negedge clk);
        de_valid = 1'b0;
`else
        drive(OP_MUL, 32'h80, 32'd7, 32'hFFFFFFFD, 32'd0);
        t0 = tag_ctr - 32'd1;
        #1;
        chk("MUL nop stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("MUL nop valid", 32'(lat_valid), 32'd1);
        chk("MUL nop regval", lat_reg, 32'd0);
        chk("MUL nop tag", lat_tag, t0);
        @(negedge clk);
        drive(OP_DIV, 32'h84, 32'hFFFFFFF9, 32'd2, 32'd0);
        #1;
        chk("DIV nop stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("DIV nop valid", 32'(lat_valid), 32'd1);
        chk("DIV nop regval", lat_reg, 32'd0);
        @(negedge clk);
        de_valid = 1'b0;
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
